wb_cpu_bus_arbiter: RTL

- Parametrised N-master to 1-slave Wishbone B3 arbiter.
- Merges CPU instruction/data masters (and optional debug/DMA masters) onto a single shared system bus port.
- Adds selectable fixed-priority or round-robin arbitration, whole-cycle bus locking, and a bus-timeout watchdog that terminates hung transfers with ERR.
- Sits between the CPU wrapper's iwbm/dwbm ports and the SoC interconnect.

---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_cpu_bus_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone CPU bus arbiter and its helpers.
// Holds the FSM encoding, arbitration mode selectors and CTI codes.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Index of the set bit of a one-hot vector of up to 8 masters.
    function automatic logic [2:0] oh_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational requester picker: fixed priority (lowest index) or
// round-robin starting at ptr. Returns a one-hot grant, zero when no request.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = mode ? ((int'(ptr) + i) % N) : i;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_cpu_bus_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with whole-cycle locking, fixed or
// round-robin arbitration, and a watchdog that ends hung transfers with ERR.
module wb_cpu_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]             m_bte_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS-1:0]               m_rty_o,
    output logic [ADDRESS_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_WIDTH/8-1:0]              s_sel_o,
    output logic [2:0]                           s_cti_o,
    output logic [1:0]                           s_bte_o,
    output logic                                 s_we_o,
    output logic                                 s_stb_o,
    output logic                                 s_cyc_o,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i,
    input  logic                                 s_rty_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o,
    output logic [1:0]                           state_o
);

    localparam int AW   = ADDRESS_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int SW   = DATA_WIDTH / 8;
    localparam int PW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] pick;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          owner;
    logic [PW-1:0]          pick_idx;
    logic [PW-1:0]          next_ptr;
    logic [TW-1:0]          timer;
    logic                   busy;
    logic                   term;
    logic                   count;
    logic                   fire;

    wb_rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
        .req   (m_cyc_i),
        .ptr   (rr_ptr),
        .mode  (ARB_MODE == ARB_RR),
        .grant (pick)
    );

    assign state_o  = state;
    assign busy     = (state == ST_BUSY);
    assign owner    = PW'(oh_index(8'(grant_o)));
    assign pick_idx = PW'(oh_index(8'(pick)));
    assign next_ptr = (int'(pick_idx) == NUM_MASTERS - 1) ? '0 : pick_idx + 1'b1;
    assign term     = s_ack_i | s_err_i | s_rty_i;
    assign count    = busy && s_stb_o && !term;
    // A slave termination on the would-be firing cycle suppresses the timeout.
    assign fire     = (TIMEOUT_CYCLES != 0) && count && (timer == TW'(TLIM));
    assign m_dat_o  = s_dat_i;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            s_adr_o = m_adr_i[owner*AW +: AW];
            s_dat_o = m_dat_i[owner*DW +: DW];
            s_sel_o = m_sel_i[owner*SW +: SW];
            s_cti_o = m_cti_i[owner*3 +: 3];
            s_bte_o = m_bte_i[owner*2 +: 2];
            s_we_o  = m_we_i[owner];
            s_stb_o = m_stb_i[owner];
            s_cyc_o = m_cyc_i[owner];
            m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
            m_err_o = grant_o & {NUM_MASTERS{s_err_i}};
            m_rty_o = grant_o & {NUM_MASTERS{s_rty_i}};
        end
        if (timeout_o) m_err_o = m_err_o | grant_o;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            grant_o   <= '0;
            rr_ptr    <= '0;
            timer     <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (|m_cyc_i) begin
                        grant_o <= pick;
                        state   <= ST_BUSY;
                        if (ARB_MODE == ARB_RR) rr_ptr <= next_ptr;
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i[owner]) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                        timer   <= '0;
                    end else if (fire) begin
                        state     <= ST_ABORT;
                        timeout_o <= 1'b1;
                        timer     <= '0;
                    end else if (count) begin
                        if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                ST_ABORT: begin
                    if (!m_cyc_i[owner]) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule
